// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of one single-port unified memory
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        stall_if,
    output logic        stall_d,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_IF = 2'd1;
    localparam logic [1:0] S_BUSY_D  = 2'd2;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
    localparam logic [7:0] SMAX   = 8'(STARVE_MAX);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [7:0]  r_starve;
    logic        r_if_ack;
    logic        r_d_ack;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;

    logic w_idle;
    logic w_if_elig;
    logic w_d_elig;
    logic w_grant_if;
    logic w_grant_d;
    logic w_unused_addr_lsbs;

    // A requester whose ack is high this cycle is still finishing its old access,
    // so it cannot compete; fetch only beats data once it has been starved enough.
    always_comb begin
        w_idle     = (r_state == S_IDLE);
        w_if_elig  = if_req & ~r_if_ack;
        w_d_elig   = d_req & ~r_d_ack;
        w_grant_if = w_idle & w_if_elig & (~w_d_elig | (r_starve == SMAX));
        w_grant_d  = w_idle & w_d_elig & ~w_grant_if;
    end

    // Byte offsets never reach the word-aligned memory port.
    assign w_unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    // Transaction FSM: grant latches the memory command, then the latency
    // counter runs down and the final busy cycle captures read data and acks.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_d_rdata   <= 32'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_be    <= 4'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_if) begin
                        r_state    <= S_BUSY_IF;
                        r_cnt      <= LAT_M1;
                        r_mem_addr <= {if_addr[31:2], 2'b00};
                        r_mem_we   <= 1'b0;
                        r_mem_be   <= 4'hF;
                    end else if (w_grant_d) begin
                        r_state     <= S_BUSY_D;
                        r_cnt       <= LAT_M1;
                        r_mem_addr  <= {d_addr[31:2], 2'b00};
                        r_mem_we    <= d_we;
                        r_mem_be    <= d_be;
                        r_mem_wdata <= d_wdata;
                    end
                end
                S_BUSY_IF: begin
                    if (r_cnt == 4'd0) begin
                        r_if_rdata <= mem_rdata;
                        r_if_ack   <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_BUSY_D: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_mem_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                        r_d_ack <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Counts data grants that bypassed a waiting fetch; any fetch-idle cycle forgives them.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_starve <= 8'd0;
        end else if (!if_req || w_grant_if) begin
            r_starve <= 8'd0;
        end else if (w_grant_d && (r_starve != SMAX)) begin
            r_starve <= r_starve + 8'd1;
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_ack    = r_if_ack;
    assign d_rdata   = r_d_rdata;
    assign d_ack     = r_d_ack;
    assign stall_if  = if_req & ~r_if_ack;
    assign stall_d   = d_req & ~r_d_ack;
    assign mem_en    = ~w_idle;
    assign busy      = ~w_idle;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule
